// File: rtl/dist_sector_resampler.sv
// Collects per-sector distance samples into a ping-pong RAM, then resamples each closed sector
// from M captured points to N output points with wrapped angle codes over valid/ready.
`timescale 1ns/1ps
module dist_sector_resampler #(
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned ANGLE_W = 16
) (
   input  logic               i_clk_50m,
   input  logic               i_rst_n,
   input  logic               i_opto_fall,
   input  logic               i_zero_sign,
   input  logic [7:0]         i_fall_cnt,
   input  logic [ANGLE_W-1:0] i_angle_zero,
   input  logic [ANGLE_W-1:0] i_angle_max,
   input  logic [ADDR_W-1:0]  i_pts_per_sector,
   input  logic               i_dist_sig,
   input  logic [DATA_W-1:0]  i_dist_data,
   input  logic               i_out_ready,
   output logic               o_dist_sig,
   output logic [ANGLE_W-1:0] o_code_angle,
   output logic [DATA_W-1:0]  o_edge_data,
   output logic               o_busy,
   output logic               o_sector_drop
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CW    = ADDR_W + 1;
   localparam int unsigned BW    = ANGLE_W + 8;

   typedef enum logic [2:0] {
      StIdle, StAngle1, StAngle2, StFetch, StWait, StValid, StStep, StEnd
   } state_e;

   state_e state_q, state_d;

   logic [DATA_W-1:0]  mem [2*DEPTH];
   logic [DATA_W-1:0]  ram_q;
   logic               bank_q, bank_d;
   logic [CW-1:0]      wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]      m_q, m_d;
   logic [ADDR_W-1:0]  n_q, n_d;
   logic [ANGLE_W-1:0] amax_q, amax_d, azero_q, azero_d;
   logic [7:0]         fall_q, fall_d;
   logic [BW-1:0]      base_q, base_d;
   logic [ANGLE_W-1:0] angle_q, angle_d;
   logic [CW-1:0]      idx_q, idx_d, acc_q, acc_d, cnt_q, cnt_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               drop_q, drop_d;

   logic               bnd, idle, wr_en;
   logic [ADDR_W:0]    wr_addr;
   logic [CW-1:0]      n_ext;
   logic [ANGLE_W:0]   angle_inc;

   assign bnd       = i_opto_fall | i_zero_sign;
   assign idle      = (state_q == StIdle);
   assign n_ext     = {1'b0, n_q};
   assign angle_inc = {1'b0, angle_q} + 1'b1;
   // A sample coinciding with a boundary opens the new sector, in the bank it will live in.
   assign wr_en     = i_dist_sig & (bnd | (wr_cnt_q < CW'(DEPTH)));
   assign wr_addr   = {(bnd & idle) ? ~bank_q : bank_q,
                       bnd ? {ADDR_W{1'b0}} : wr_cnt_q[ADDR_W-1:0]};

   always_ff @(posedge i_clk_50m) begin
      if (wr_en) begin
         mem[wr_addr] <= i_dist_data;
      end
      ram_q <= mem[{~bank_q, idx_q[ADDR_W-1:0]}];
   end

   always_comb begin
      state_d  = state_q;
      bank_d   = bank_q;
      wr_cnt_d = wr_cnt_q;
      m_d      = m_q;
      n_d      = n_q;
      amax_d   = amax_q;
      azero_d  = azero_q;
      fall_d   = fall_q;
      base_d   = base_q;
      angle_d  = angle_q;
      idx_d    = idx_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      drop_d   = bnd & ~idle;

      if (bnd) begin
         wr_cnt_d = i_dist_sig ? CW'(1) : '0;
      end else if (i_dist_sig && (wr_cnt_q < CW'(DEPTH))) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (bnd) begin
               m_d     = wr_cnt_q;
               n_d     = i_pts_per_sector;
               amax_d  = i_angle_max;
               azero_d = i_angle_zero;
               fall_d  = i_fall_cnt;
               bank_d  = ~bank_q;
               idx_d   = '0;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = StAngle1;
            end
         end
         StAngle1: begin
            base_d  = BW'(fall_q) * BW'(n_q) + BW'(azero_q);
            state_d = StAngle2;
         end
         StAngle2: begin
            if (base_q >= BW'(amax_q)) begin
               angle_d = ANGLE_W'(base_q - BW'(amax_q));
            end else begin
               angle_d = base_q[ANGLE_W-1:0];
            end
            state_d = (n_q == '0) ? StEnd : StFetch;
         end
         StFetch: state_d = StWait;
         StWait: begin
            data_d  = (m_q == '0) ? '0 : ram_q;
            state_d = StValid;
         end
         StValid: begin
            if (i_out_ready) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == n_ext) begin
                  state_d = StEnd;
               end else begin
                  angle_d = (angle_inc == {1'b0, amax_q}) ? '0 : angle_inc[ANGLE_W-1:0];
                  acc_d   = acc_q + m_q;
                  state_d = StStep;
               end
            end
         end
         StStep: begin
            // One subtraction per cycle; leave as soon as the remainder drops below N.
            if (acc_q >= n_ext) begin
               acc_d = acc_q - n_ext;
               if (idx_q + 1'b1 < m_q) begin
                  idx_d = idx_q + 1'b1;
               end
               if (acc_d < n_ext) begin
                  state_d = StFetch;
               end
            end else begin
               state_d = StFetch;
            end
         end
         StEnd:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= StIdle;
         bank_q   <= 1'b0;
         wr_cnt_q <= '0;
         m_q      <= '0;
         n_q      <= '0;
         amax_q   <= '0;
         azero_q  <= '0;
         fall_q   <= '0;
         base_q   <= '0;
         angle_q  <= '0;
         idx_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bank_q   <= bank_d;
         wr_cnt_q <= wr_cnt_d;
         m_q      <= m_d;
         n_q      <= n_d;
         amax_q   <= amax_d;
         azero_q  <= azero_d;
         fall_q   <= fall_d;
         base_q   <= base_d;
         angle_q  <= angle_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         drop_q   <= drop_d;
      end
   end

   assign o_dist_sig    = (state_q == StValid);
   assign o_code_angle  = angle_q;
   assign o_edge_data   = data_q;
   assign o_busy        = ~idle;
   assign o_sector_drop = drop_q;

endmodule

// File: tb/tb_dist_sector_resampler.sv
// Randomised bench for dist_sector_resampler: each sector's output stream is compared against
// floor(k*M/N) source indexing and (base+k) mod angle_max angle codes.
`timescale 1ns/1ps
module tb_dist_sector_resampler;

   localparam int DEPTH = 512;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        opto_fall = 1'b0, zero_sign = 1'b0;
   logic [7:0]  fall_cnt = '0;
   logic [15:0] angle_zero = '0, angle_max = '0;
   logic [8:0]  pts = '0;
   logic        dist_sig = 1'b0;
   logic [63:0] dist_data = '0;
   logic        out_ready = 1'b0;
   logic        dist_sig_o, busy, sector_drop;
   logic [15:0] code_angle;
   logic [63:0] edge_data;

   int checks = 0;
   int errors = 0;

   logic [63:0] sec_q[$];
   logic [63:0] closed_q[$];
   logic [63:0] exp_data[$];
   int          exp_ang[$];

   always #10 clk = ~clk;

   dist_sector_resampler dut (
      .i_clk_50m       (clk),
      .i_rst_n         (rst_n),
      .i_opto_fall     (opto_fall),
      .i_zero_sign     (zero_sign),
      .i_fall_cnt      (fall_cnt),
      .i_angle_zero    (angle_zero),
      .i_angle_max     (angle_max),
      .i_pts_per_sector(pts),
      .i_dist_sig      (dist_sig),
      .i_dist_data     (dist_data),
      .i_out_ready     (out_ready),
      .o_dist_sig      (dist_sig_o),
      .o_code_angle    (code_angle),
      .o_edge_data     (edge_data),
      .o_busy          (busy),
      .o_sector_drop   (sector_drop)
   );

   task automatic drive_samples(input int count);
      int sent = 0;
      while (sent < count) begin
         @(posedge clk); #1;
         if ($urandom_range(3) == 0) begin
            dist_sig = 1'b0;
         end else begin
            dist_sig  = 1'b1;
            dist_data = {$urandom, $urandom};
            if (sec_q.size() < DEPTH) sec_q.push_back(dist_data);
            sent++;
         end
      end
      @(posedge clk); #1;
      dist_sig = 1'b0;
   endtask

   task automatic pulse_boundary(input int fall, input int zero, input int amax, input int n,
                                 input bit with_sample, input bit use_zero);
      @(posedge clk); #1;
      if (use_zero) zero_sign = 1'b1;
      else opto_fall = 1'b1;
      fall_cnt   = 8'(fall);
      angle_zero = 16'(zero);
      angle_max  = 16'(amax);
      pts        = 9'(n);
      closed_q   = sec_q;
      sec_q.delete();
      if (with_sample) begin
         dist_sig  = 1'b1;
         dist_data = {$urandom, $urandom};
         sec_q.push_back(dist_data);
      end
      @(posedge clk); #1;
      opto_fall = 1'b0;
      zero_sign = 1'b0;
      dist_sig  = 1'b0;
   endtask

   task automatic build_expected(input int fall, input int zero, input int amax, input int n);
      int m = closed_q.size();
      longint base = longint'(fall) * n + zero;
      if (base >= amax) base -= amax;
      exp_data.delete();
      exp_ang.delete();
      for (int k = 0; k < n; k++) begin
         exp_data.push_back((m == 0) ? 64'd0 : closed_q[(k * m) / n]);
         exp_ang.push_back(int'((base + k) % amax));
      end
   endtask

   task automatic collect(input string name, input int rdy_pct, output int span);
      int k = 0, cyc = 0, extra = 0, first = -1, last = 0;
      int n = exp_data.size();
      bit holding = 0;
      logic [63:0] hd;
      logic [15:0] ha;
      while (k < n && cyc < 20000) begin
         @(posedge clk); #1;
         cyc++;
         if (holding) begin
            checks++;
            if (dist_sig_o !== 1'b1 || edge_data !== hd || code_angle !== ha) begin
               errors++;
               $display("FAIL %s hold k=%0d: valid=%b data=%h angle=%0d, required valid=1 data=%h angle=%0d",
                        name, k, dist_sig_o, edge_data, code_angle, hd, ha);
            end
         end
         out_ready = ($urandom_range(99) < rdy_pct);
         holding = 0;
         if (dist_sig_o === 1'b1) begin
            if (out_ready) begin
               checks++;
               if (edge_data !== exp_data[k] || code_angle !== 16'(exp_ang[k])) begin
                  errors++;
                  $display("FAIL %s point %0d: data=%h angle=%0d, required data=%h angle=%0d",
                           name, k, edge_data, code_angle, exp_data[k], exp_ang[k]);
               end
               if (first < 0) first = cyc;
               last = cyc;
               k++;
            end else begin
               holding = 1;
               hd = edge_data;
               ha = code_angle;
            end
         end
      end
      checks++;
      if (k != n) begin
         errors++;
         $display("FAIL %s count: got %0d transfers, required %0d", name, k, n);
      end
      cyc = 0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      while (busy === 1'b1 && cyc < 100) begin
         if (dist_sig_o === 1'b1) extra++;
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b0;
      checks++;
      if (extra != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s drain: extra valid cycles=%0d busy=%b, required 0 and 0", name, extra, busy);
      end
      span = (first < 0) ? 0 : last - first;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({dist_sig_o, busy, sector_drop} !== 3'b000) begin
         errors++;
         $display("FAIL reset flags: valid/busy/drop=%b, required 000", {dist_sig_o, busy, sector_drop});
      end
      checks++;
      if (edge_data !== 64'd0 || code_angle !== 16'd0) begin
         errors++;
         $display("FAIL reset data: data=%h angle=%0d, required 0 and 0", edge_data, code_angle);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_latency();
      int span;
      drive_samples(10);
      out_ready = 1'b0;
      pulse_boundary(2, 0, 3600, 5, 0, 0);
      build_expected(2, 0, 3600, 5);
      checks++;
      if (busy !== 1'b1 || sector_drop !== 1'b0 || dist_sig_o !== 1'b0) begin
         errors++;
         $display("FAIL latency start: busy=%b drop=%b valid=%b, required 1 0 0", busy, sector_drop, dist_sig_o);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (dist_sig_o !== 1'b0) begin
            errors++;
            $display("FAIL latency early valid at cycle %0d: valid=%b, required 0", i + 2, dist_sig_o);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (dist_sig_o !== 1'b1) begin
         errors++;
         $display("FAIL latency valid at cycle 5: valid=%b, required 1", dist_sig_o);
      end
      collect("latency", 100, span);
   endtask

   task automatic test_identity();
      int span;
      drive_samples(90);
      pulse_boundary(3, 10, 3600, 90, 0, 0);
      build_expected(3, 10, 3600, 90);
      collect("identity", 100, span);
      checks++;
      if (span > 89 * 4) begin
         errors++;
         $display("FAIL identity throughput: span=%0d cycles, required <= %0d", span, 89 * 4);
      end
   endtask

   task automatic test_resample(input string name, input int m, input int n);
      int span;
      int fall = $urandom_range(15);
      int zero = $urandom_range(3599);
      drive_samples(m);
      pulse_boundary(fall, zero, 3600, n, 0, 1);
      build_expected(fall, zero, 3600, n);
      collect(name, 100, span);
   endtask

   task automatic test_angles();
      int span;
      drive_samples(20);
      pulse_boundary(39, 100, 3600, 90, 0, 0);
      build_expected(39, 100, 3600, 90);
      collect("angle_base10", 70, span);
      drive_samples(50);
      pulse_boundary(39, 0, 3600, 100, 0, 0);
      build_expected(39, 0, 3600, 100);
      collect("angle_base300", 70, span);
      drive_samples(7);
      pulse_boundary(0, 3590, 3600, 20, 0, 0);
      build_expected(0, 3590, 3600, 20);
      collect("angle_wrap", 70, span);
   endtask

   task automatic test_ready_random();
      int span;
      for (int i = 0; i < 3; i++) begin
         int m = $urandom_range(300, 1);
         int n = $urandom_range(200, 1);
         int fall = $urandom_range(15);
         int zero = $urandom_range(3599);
         drive_samples(m);
         pulse_boundary(fall, zero, 3600, n, 0, 0);
         build_expected(fall, zero, 3600, n);
         collect("ready_random", 40, span);
      end
   endtask

   task automatic test_drop();
      int span;
      out_ready = 1'b0;
      drive_samples(30);
      pulse_boundary(5, 7, 3600, 12, 0, 0);
      build_expected(5, 7, 3600, 12);
      drive_samples(20);
      pulse_boundary(9, 3, 7200, 40, 0, 0);
      checks++;
      if (sector_drop !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL drop pulse: drop=%b busy=%b, required 1 and 1", sector_drop, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (sector_drop !== 1'b0) begin
         errors++;
         $display("FAIL drop width: drop=%b on second cycle, required 0", sector_drop);
      end
      collect("drop_current", 60, span);
      drive_samples(25);
      pulse_boundary(4, 50, 3600, 25, 0, 0);
      build_expected(4, 50, 3600, 25);
      collect("drop_next", 100, span);
   endtask

   task automatic test_n_zero();
      int cyc = 0, seen = 0;
      drive_samples(5);
      out_ready = 1'b1;
      pulse_boundary(1, 0, 3600, 0, 0, 0);
      while (busy === 1'b1 && cyc < 50) begin
         if (dist_sig_o === 1'b1) seen++;
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b0;
      checks++;
      if (seen != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL n_zero: valid cycles=%0d busy=%b, required 0 and 0", seen, busy);
      end
   endtask

   task automatic test_back_to_back();
      int span;
      drive_samples(30);
      pulse_boundary(2, 0, 3600, 30, 1, 0);
      build_expected(2, 0, 3600, 30);
      collect("b2b_first", 100, span);
      drive_samples(29);
      pulse_boundary(6, 11, 3600, 30, 0, 1);
      build_expected(6, 11, 3600, 30);
      collect("b2b_coincident", 100, span);
   endtask

   task automatic test_reset_mid();
      int span, cyc = 0;
      drive_samples(20);
      out_ready = 1'b0;
      pulse_boundary(1, 0, 3600, 10, 0, 0);
      while (dist_sig_o !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (dist_sig_o !== 1'b0 || busy !== 1'b0 || edge_data !== 64'd0 || code_angle !== 16'd0) begin
         errors++;
         $display("FAIL reset_mid: valid=%b busy=%b data=%h angle=%0d, required all 0",
                  dist_sig_o, busy, edge_data, code_angle);
      end
      sec_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive_samples(15);
      pulse_boundary(8, 20, 3600, 15, 0, 0);
      build_expected(8, 20, 3600, 15);
      collect("reset_restart", 100, span);
   endtask

   initial begin
      test_reset();
      test_latency();
      test_identity();
      test_resample("decimate", 180, 90);
      test_resample("repeat", 45, 90);
      test_angles();
      test_ready_random();
      test_drop();
      test_resample("saturate", 600, 16);
      test_resample("m_zero", 0, 4);
      test_n_zero();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dist_sector_resampler.md
Name: dist_sector_resampler

Overview:
- Parametrised successor to the per-sector distance point buffer.
- Collects raw distance/edge samples between opto-tooth boundaries into a ping-pong RAM.
- Uniformly resamples each sector from M captured points to exactly N output points, using accumulator-based index stepping instead of a divider. Each output point carries a wrapped encoder angle code.
- Drives the packet/uart formatter over a valid/ready handshake rather than a fixed inter-point delay.

Parameters:
DATA_W, 64, width of one sample word ({rise,fall,dist,rssi} packed upstream)
ADDR_W, 9, RAM address width; DEPTH = 2**ADDR_W samples per bank
ANGLE_W, 16, width of angle code, zero offset and angle max

Ports:
i_clk_50m  in  1  system clock, 50 MHz
i_rst_n  in  1  asynchronous active-low reset
i_opto_fall  in  1  sector boundary pulse (tooth edge)
i_zero_sign  in  1  sector boundary pulse (zero tooth); OR-ed with i_opto_fall
i_fall_cnt  in  8  tooth index of the sector just closed
i_angle_zero  in  ANGLE_W  angle zero offset
i_angle_max  in  ANGLE_W  angle codes per revolution (e.g. 3600/7200)
i_pts_per_sector  in  ADDR_W  N, output points per sector
i_dist_sig  in  1  sample strobe
i_dist_data  in  DATA_W  sample word
i_out_ready  in  1  downstream ready
o_dist_sig  out  1  output valid
o_code_angle  out  ANGLE_W  angle code of current output point
o_edge_data  out  DATA_W  output sample word
o_busy  out  1  read engine not in IDLE
o_sector_drop  out  1  one-cycle pulse: closed sector discarded

Behaviour:
- Reset (async, any time, including mid-readout): all outputs 0, write count 0, bank select 0, FSM IDLE. RAM contents are don't-care.
- Boundary b = i_opto_fall | i_zero_sign.
- Write side:
  - Each i_dist_sig writes i_dist_data to the write bank at address wr_cnt, then wr_cnt++.
  - wr_cnt saturates at DEPTH; further samples in that sector are dropped.
  - If i_dist_sig and b coincide, the sample is the first sample (address 0) of the new sector.
- On b with FSM IDLE:
  - Latch M = wr_cnt, N = i_pts_per_sector, i_angle_max, i_angle_zero, i_fall_cnt.
  - Toggle bank; reset wr_cnt (to 1 if a sample coincided, else 0).
  - Start readout of the closed bank.
- On b with FSM busy:
  - Do not toggle bank or start a readout; reset wr_cnt (same rule as above).
  - Pulse o_sector_drop for one cycle. The readout in progress continues undisturbed.
- FSM states: IDLE, ANGLE, FETCH, WAIT, VALID, STEP, END.
  - ANGLE (2 cycles): base = fall_cnt*N + angle_zero, computed at ANGLE_W+8 bits.
    - If base >= angle_max, subtract angle_max once.
    - If N == 0, go to END with no output.
  - FETCH: drive RAM read address idx. WAIT: 1-cycle RAM latency.
  - VALID:
    - Data word = RAM output, or 0 when M == 0.
    - o_dist_sig = 1; o_edge_data and o_code_angle are held stable until i_out_ready is sampled high.
    - The transfer occurs on the clock edge with o_dist_sig & i_out_ready. o_dist_sig deasserts on the next cycle unless re-entered.
  - STEP (after each transfer): out_cnt++.
    - If out_cnt == N, go to END.
    - Else angle = (angle+1 == angle_max) ? 0 : angle+1, and acc += M.
    - Then, one subtraction per cycle, while acc >= N: acc -= N, idx++. Stay in STEP until acc < N, then go to FETCH.
    - idx is clamped to M-1.
  - END: 1 cycle, then IDLE. A boundary in END counts as busy.
- Resampling rule:
  - Output k (0..N-1) uses source index floor(k*M/N), with idx starting at 0 and acc starting at 0.
  - M == N gives identity; M > N decimates evenly; M < N repeats samples evenly.
- Widths: acc is ADDR_W+1 bits; out_cnt and idx are ADDR_W+1 bits. No wrap is permitted.
- Latency, boundary to first o_dist_sig: 5 cycles (ANGLE 2, FETCH, WAIT, VALID entry).
- Throughput with i_out_ready held high: one point per (3 + ceil(M/N)) cycles, maximum.

Test Plan:
- M=90, N=90, fall_cnt=3, angle_zero=10, angle_max=3600, ready=1 → 90 transfers, data = samples 0..89 in order, angles 280..369.
- M=180, N=90 → source indices 0,2,4,…,178; M=45, N=90 → each sample emitted twice (0,0,1,1,…); exactly 90 transfers in both cases.
- fall_cnt=39, N=90, angle_zero=100, angle_max=3600 → base 3610-3600=10. With fall_cnt=39, N=100, angle_zero=0, base=3900-3600=300; at angle_max=3600 and a base near the top, the code wraps 3599→0.
- i_out_ready toggled randomly → no lost or duplicated transfers; o_edge_data and o_code_angle stable while valid and not ready.
- Second boundary arriving mid-readout (ready held low) → o_sector_drop pulses once, current readout completes intact; the next boundary after IDLE reads the most recently written sector.
- 600 samples with DEPTH=512 → M=512; M=0 with N=4 → four zero words; reset asserted mid-VALID → o_dist_sig=0 immediately, bank 0, and a clean restart on the next boundary.
